// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, datapath widths and the
// default boot address.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // BOOT: one settling cycle after reset, no requests.
    // RUN : normal sequential fetching.
    // HALT: terminal after a misaligned redirect; left only by reset.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Small synchronous in-order FIFO with a single-cycle flush and an
// occupancy count. DEPTH must be a power of two so the pointers wrap
// naturally. Flush has priority over push and pop in the same cycle.
module cpu_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];
    assign do_pop = pop && !empty;

    // Pointer and occupancy bookkeeping; flush empties the queue at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Entry storage; written on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // A push into a full queue is only legal when the head leaves the same cycle.
    assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> ((int'(count) < DEPTH) || pop))
        else $error("cpu_fetch_fifo overflow");

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: issues sequential word requests, tags each with
// its PC, buffers returned words and hands {instruction, PC} to decode.
// Redirects flush everything and squash responses still in flight.
// Optional feature macro: CPU_FETCH_ALIGN_CHECK_EN (misaligned redirect
// target halts fetch and raises o_fetch_fault).
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at the rising clock edge. valid never depends combinationally on
// ready. The memory response channel has no ready: every i_mem_rsp_valid
// pulse is one word that must be taken.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_mem_req_valid,
    output logic [XLEN-1:0] o_mem_req_addr,
    input  logic            i_mem_req_ready,
    input  logic            i_mem_rsp_valid,
    input  logic [ILEN-1:0] i_mem_rsp_data,
    output logic            o_inst_valid,
    output logic [ILEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_ready,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [XLEN-1:0]       pc_q;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         outstanding_d;
    logic [CW-1:0]         drop_q;
    logic [CW:0]           in_use;
    logic                  req_fire;
    logic                  rsp_keep;
    logic                  inst_pop;
    logic                  misaligned;
    logic [XLEN-1:0]       redirect_target;

    logic [XLEN+ILEN-1:0]  fifo_head;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [XLEN-1:0]       pcq_head;
    logic                  pcq_empty;
    logic [CW-1:0]         pcq_count;

    // Word-aligned redirect target; the low two bits never reach the PC.
    assign redirect_target = i_redirect_pc & ~XLEN'(3);

`ifdef CPU_FETCH_ALIGN_CHECK_EN
    assign misaligned    = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    assign o_fetch_fault = (state_q == HALT);
`else
    assign misaligned    = 1'b0;
    assign o_fetch_fault = 1'b0;
`endif

    // Credits: words in flight plus words buffered may never exceed the buffer.
    assign in_use          = (CW + 1)'(outstanding_q) + (CW + 1)'(fifo_count);
    assign o_mem_req_valid = (state_q == RUN) && (in_use < (CW + 1)'(FIFO_DEPTH));
    assign o_mem_req_addr  = pc_q;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;

    assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(i_mem_rsp_valid);
    assign rsp_keep      = i_mem_rsp_valid && (drop_q == '0) && !i_redirect_valid;

    assign o_inst_valid = !fifo_empty;
    assign o_inst       = fifo_empty ? '0 : fifo_head[ILEN-1:0];
    assign o_inst_pc    = fifo_empty ? '0 : fifo_head[XLEN+ILEN-1:ILEN];
    assign inst_pop     = o_inst_valid && i_inst_ready;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: BOOT lasts one cycle, HALT is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
        if (misaligned) begin
            state_d = HALT;
        end
    end

    // Fetch PC: redirect wins over sequential advance; wraps modulo 2^32.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else if (i_redirect_valid) begin
            pc_q <= redirect_target;
        end else if (req_fire) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

    // In-flight and to-be-discarded counts; a redirect marks all in-flight as stale.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (i_redirect_valid) begin
                drop_q <= outstanding_d;
            end else if (i_mem_rsp_valid && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

    // PCs of live in-flight requests, consumed by their responses in order.
    cpu_fetch_fifo #(
        .W     (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect_valid),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    // Instruction buffer presented to decode.
    cpu_fetch_fifo #(
        .W     (XLEN + ILEN),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect_valid),
        .push      (rsp_keep),
        .push_data ({pcq_head, i_mem_rsp_data}),
        .pop       (inst_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A response with nothing in flight is a memory protocol error.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_mem_rsp_valid |-> (outstanding_q != '0))
        else $error("cpu_fetch: response with nothing outstanding");

    // A kept response always has a matching PC tag.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        rsp_keep |-> !pcq_empty)
        else $error("cpu_fetch: response without PC tag");

    // Stale plus live in-flight requests account for everything outstanding.
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ((CW + 1)'(drop_q) + (CW + 1)'(pcq_count)) == (CW + 1)'(outstanding_q))
        else $error("cpu_fetch: drop/outstanding bookkeeping broken");

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: a memory model with random latency, random decode
// back-pressure and redirects, checked against an epoch-based reference
// model of the fetch stage.
module tb_cpu_fetch;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [63:0] exp_q[$];        // {pc, inst} words deliverable to decode
    logic [31:0] mem_addr_q[$];   // requests accepted by memory, in order
    int          mem_epoch_q[$];  // redirect epoch each request was issued in
    logic [31:0] m_pc;
    int          m_epoch;
    bit          m_running;
    bit          m_halted;

    cpu_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_mem_req_valid  (mem_req_valid),
        .o_mem_req_addr   (mem_req_addr),
        .i_mem_req_ready  (mem_req_ready),
        .i_mem_rsp_valid  (mem_rsp_valid),
        .i_mem_rsp_data   (mem_rsp_data),
        .o_inst_valid     (inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .i_inst_ready     (inst_ready),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_fetch_fault    (fetch_fault)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_addr_q.delete();
        mem_epoch_q.delete();
        m_pc      = 32'h0000_0000;
        m_epoch   = 0;
        m_running = 1'b0;
        m_halted  = 1'b0;
    endtask

    task automatic drive_idle();
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    // Reset outputs must all read zero.
    task automatic check_reset_outputs();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_fault", 64'(fetch_fault), 64'd0);
    endtask

    // Called at a falling edge; asserts reset asynchronously, releases at a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: check outputs at the falling edge, drive inputs, let the
    // rising edge happen, advance the model, and return at the next falling edge.
    task automatic step(input bit rdy, input bit rsp_en, input bit irdy,
                        input bit redir, input logic [31:0] rpc);
        bit          exp_rv;
        bit          fire;
        bit          rsp;
        bit          pop;
        logic [31:0] r_addr;
        int          r_epoch;
        logic [63:0] head;

        exp_rv = m_running && !m_halted && ((mem_addr_q.size() + exp_q.size()) < DEPTH);
        check("req_valid", 64'(mem_req_valid), 64'(exp_rv));
        if (exp_rv) check("req_addr", 64'(mem_req_addr), 64'(m_pc));
        check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("inst_pc", 64'(inst_pc), 64'(head[63:32]));
            check("inst", 64'(inst), 64'(head[31:0]));
        end
        check("fault", 64'(fetch_fault), 64'(m_halted));

        rsp = rsp_en && (mem_addr_q.size() != 0);
        mem_req_ready  = rdy;
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? mem_word(mem_addr_q[0]) : 32'h0;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;

        @(posedge clk);
        fire    = exp_rv && rdy;
        pop     = (exp_q.size() != 0) && irdy;
        r_addr  = '0;
        r_epoch = -1;
        if (rsp) begin
            r_addr  = mem_addr_q.pop_front();
            r_epoch = mem_epoch_q.pop_front();
        end
        if (redir) begin
            exp_q.delete();
            if (fire) begin
                mem_addr_q.push_back(m_pc);
                mem_epoch_q.push_back(m_epoch);
            end
            m_epoch++;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) m_halted = 1'b1;
`endif
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (rsp && (r_epoch == m_epoch)) exp_q.push_back({r_addr, mem_word(r_addr)});
            if (fire) begin
                mem_addr_q.push_back(m_pc);
                mem_epoch_q.push_back(m_epoch);
                m_pc = m_pc + 32'd4;
            end
        end
        m_running = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Straight-line fetch with fast memory and an always-ready decoder.
        repeat (8) step(1, 1, 1, 0, 32'h0);

        // Decode stalled: credits cap requests; one pop frees one request.
        repeat (6) step(1, 1, 0, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        repeat (3) step(1, 1, 0, 0, 32'h0);
        repeat (4) step(1, 1, 1, 0, 32'h0);

        // Requests in flight when a redirect lands: their words are squashed.
        step(1, 0, 1, 1, 32'h0000_0010);
        repeat (2) step(1, 0, 1, 0, 32'h0);
        step(1, 0, 1, 1, 32'h0000_0100);
        repeat (8) step(1, 1, 1, 0, 32'h0);

        // Response in the redirect cycle, then redirect together with a pop.
        repeat (2) step(1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 1, 32'h0000_0200);
        repeat (4) step(1, 1, 0, 0, 32'h0);
        step(0, 0, 1, 1, 32'h0000_0300);
        repeat (6) step(1, 1, 1, 0, 32'h0);

        // Address wrap past the top of memory.
        step(1, 1, 1, 1, 32'hFFFF_FFF8);
        repeat (8) step(1, 1, 1, 0, 32'h0);

        // Reset in the middle of traffic, then a redirect during BOOT.
        apply_reset();
        step(1, 1, 1, 1, 32'h0000_0200);
        repeat (6) step(1, 1, 1, 0, 32'h0);

        // Randomized traffic with aligned redirects.
        for (int i = 0; i < 2000; i++) begin
            bit          rdy;
            bit          rsp_en;
            bit          irdy;
            bit          redir;
            logic [31:0] rpc;
            rdy    = ($urandom_range(0, 3) != 0);
            rsp_en = ($urandom_range(0, 2) != 0);
            irdy   = ($urandom_range(0, 3) != 0);
            redir  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else                          rpc = $urandom() & 32'hFFFF_FFFC;
            step(rdy, rsp_en, irdy, redir, rpc);
        end
        repeat (6) step(1, 1, 1, 0, 32'h0);

        // Misaligned redirect target.
        step(1, 1, 1, 1, 32'h0000_0102);
        repeat (8) step(1, 1, 1, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
